// File: rtl/scr1_dbgc_pkg.sv
// scr1_dbgc_pkg: shared debug-controller types and DAP chain ids.
// Holds chain-id constants and the DAP chain FSM state enum.
package scr1_dbgc_pkg;

    localparam int SCR1_DBGC_DAP_CH_ID_WIDTH = 2;

    localparam logic [SCR1_DBGC_DAP_CH_ID_WIDTH-1:0] SCR1_DBGC_DAP_CH_CTRL   = 2'd0;
    localparam logic [SCR1_DBGC_DAP_CH_ID_WIDTH-1:0] SCR1_DBGC_DAP_CH_DATA   = 2'd1;
    localparam logic [SCR1_DBGC_DAP_CH_ID_WIDTH-1:0] SCR1_DBGC_DAP_CH_STATUS = 2'd2;
    localparam logic [SCR1_DBGC_DAP_CH_ID_WIDTH-1:0] SCR1_DBGC_DAP_CH_BYPASS = 2'd3;

    typedef enum logic [1:0] {
        SCR1_DAP_CHAIN_IDLE    = 2'd0,
        SCR1_DAP_CHAIN_RD_WAIT = 2'd1,
        SCR1_DAP_CHAIN_WR_WAIT = 2'd2
    } type_scr1_dap_chain_fsm_e;

endpackage

// File: rtl/scr1_dbgc_dap_sreg.sv
// scr1_dbgc_dap_sreg: DATA_W-bit chain shift register, parallel load, optional bypass bit.
// Ports: clk, rst_n, load/load_data, shift/tdi, byp_shift/byp_clr, active -> sreg, tdo. Macro: SCR1_DBGC_DAP_BYPASS_EN.
module scr1_dbgc_dap_sreg
    import scr1_dbgc_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              shift,
    input  logic              tdi,
    input  logic              byp_shift,
    input  logic              byp_clr,
    input  logic              active,
    output logic [DATA_W-1:0] sreg,
    output logic              tdo
);

    // Load wins over shift; the top never asserts both in a legal cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= load_data;
        end else if (shift) begin
            sreg <= {tdi, sreg[DATA_W-1:1]};
        end
    end

`ifdef SCR1_DBGC_DAP_BYPASS_EN
    logic byp;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byp <= 1'b0;
        end else if (byp_clr) begin
            byp <= 1'b0;
        end else if (byp_shift) begin
            byp <= tdi;
        end
    end

    // Caller gates byp onto tdo only while the bypass chain is selected.
    assign tdo = active ? sreg[0] : byp;
`else
    logic unused_byp;
    assign unused_byp = byp_shift ^ byp_clr;
    assign tdo        = active ? sreg[0] : 1'b0;
`endif

endmodule

// File: rtl/scr1_dbgc_dap_chain.sv
// scr1_dbgc_dap_chain: SysCLK DAP scan-chain engine; capture/update -> rd/wr handshakes.
// Ports: DAP strobes in, dap_ch_tdo_core out, rd_req/rd_ack, wr_req/wr_ack, seq_err. Macro: SCR1_DBGC_DAP_BYPASS_EN.
module scr1_dbgc_dap_chain
    import scr1_dbgc_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int CH_ID_W = SCR1_DBGC_DAP_CH_ID_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               dap_ch_sel_core,
    input  logic [CH_ID_W-1:0] dap_ch_id_core,
    input  logic               dap_ch_capture_core,
    input  logic               dap_ch_shift_core,
    input  logic               dap_ch_update_core,
    input  logic               dap_ch_tdi_core,
    output logic               dap_ch_tdo_core,
    output logic               rd_req,
    output logic [CH_ID_W-1:0] rd_ch,
    input  logic               rd_ack,
    input  logic [DATA_W-1:0]  rd_data,
    output logic               wr_req,
    output logic [CH_ID_W-1:0] wr_ch,
    output logic [DATA_W-1:0]  wr_data,
    input  logic               wr_ack,
    output logic               seq_err
);

    type_scr1_dap_chain_fsm_e state;

    logic              active;
    logic              bypass_sel;
    logic              cap;
    logic              upd;
    logic              shf;
    logic              sreg_load;
    logic              sreg_shift;
    logic              tdo_mux;
    logic [DATA_W-1:0] sreg;

    // All-ones id is the bypass chain and never touches the data register.
    assign active     = dap_ch_sel_core && !(&dap_ch_id_core);
    assign bypass_sel = dap_ch_sel_core && (&dap_ch_id_core);

    assign cap = dap_ch_capture_core && active;
    assign upd = dap_ch_update_core  && active;
    assign shf = dap_ch_shift_core   && active;

    assign sreg_load  = (state == SCR1_DAP_CHAIN_RD_WAIT) && rd_ack;
    assign sreg_shift = shf && (state != SCR1_DAP_CHAIN_RD_WAIT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= SCR1_DAP_CHAIN_IDLE;
            rd_req  <= 1'b0;
            rd_ch   <= '0;
            wr_req  <= 1'b0;
            wr_ch   <= '0;
            wr_data <= '0;
            seq_err <= 1'b0;
        end else begin
            unique case (state)
                SCR1_DAP_CHAIN_IDLE: begin
                    if (cap) begin
                        rd_req <= 1'b1;
                        rd_ch  <= dap_ch_id_core;
                        state  <= SCR1_DAP_CHAIN_RD_WAIT;
                    end else if (upd) begin
                        wr_req  <= 1'b1;
                        wr_ch   <= dap_ch_id_core;
                        wr_data <= sreg;
                        state   <= SCR1_DAP_CHAIN_WR_WAIT;
                    end
                end
                SCR1_DAP_CHAIN_RD_WAIT: begin
                    if (rd_ack) begin
                        rd_req <= 1'b0;
                        state  <= SCR1_DAP_CHAIN_IDLE;
                    end
                    // A capture coinciding with the ack still counts as an error.
                    if (cap || upd || shf) begin
                        seq_err <= 1'b1;
                    end
                end
                SCR1_DAP_CHAIN_WR_WAIT: begin
                    if (wr_ack) begin
                        wr_req <= 1'b0;
                        state  <= SCR1_DAP_CHAIN_IDLE;
                    end
                    // Shifting is fine here: wr_data was latched on update.
                    if (cap || upd) begin
                        seq_err <= 1'b1;
                    end
                end
                default: begin
                    state <= SCR1_DAP_CHAIN_IDLE;
                end
            endcase
        end
    end

    scr1_dbgc_dap_sreg #(
        .DATA_W (DATA_W)
    ) i_sreg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (sreg_load),
        .load_data (rd_data),
        .shift     (sreg_shift),
        .tdi       (dap_ch_tdi_core),
        .byp_shift (dap_ch_shift_core && bypass_sel),
        .byp_clr   (dap_ch_capture_core && bypass_sel),
        .active    (active),
        .sreg      (sreg),
        .tdo       (tdo_mux)
    );

    assign dap_ch_tdo_core = (active || bypass_sel) ? tdo_mux : 1'b0;

endmodule

// File: tb/tb_scr1_dbgc_dap_chain.sv
// tb_scr1_dbgc_dap_chain: directed bench with a cycle model and literal checks.
// Drives DAP strobes and rd/wr handshakes; prints CHECKS/ERRORS summary.
module tb_scr1_dbgc_dap_chain;
    import scr1_dbgc_pkg::*;

    localparam int DW = 32;
    localparam int IW = SCR1_DBGC_DAP_CH_ID_WIDTH;

    logic          clk;
    logic          rst_n;
    logic          sel;
    logic [IW-1:0] id;
    logic          cap_s;
    logic          sh_s;
    logic          upd_s;
    logic          tdi;
    logic          tdo;
    logic          rd_req;
    logic [IW-1:0] rd_ch;
    logic          rd_ack;
    logic [DW-1:0] rd_data;
    logic          wr_req;
    logic [IW-1:0] wr_ch;
    logic [DW-1:0] wr_data;
    logic          wr_ack;
    logic          seq_err;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    scr1_dbgc_dap_chain #(
        .DATA_W  (DW),
        .CH_ID_W (IW)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .dap_ch_sel_core     (sel),
        .dap_ch_id_core      (id),
        .dap_ch_capture_core (cap_s),
        .dap_ch_shift_core   (sh_s),
        .dap_ch_update_core  (upd_s),
        .dap_ch_tdi_core     (tdi),
        .dap_ch_tdo_core     (tdo),
        .rd_req              (rd_req),
        .rd_ch               (rd_ch),
        .rd_ack              (rd_ack),
        .rd_data             (rd_data),
        .wr_req              (wr_req),
        .wr_ch               (wr_ch),
        .wr_data             (wr_data),
        .wr_ack              (wr_ack),
        .seq_err             (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Model: pending read/write flags plus the chain contents.
    logic          m_rd_pend, m_wr_pend, m_err, m_byp;
    logic [IW-1:0] m_rd_ch, m_wr_ch;
    logic [DW-1:0] m_wr_data, m_chain;

    function automatic logic m_tdo();
        logic data_sel;
        data_sel = sel && (id != 2'd3);
        if (data_sel) return m_chain[0];
`ifdef SCR1_DBGC_DAP_BYPASS_EN
        if (sel) return m_byp;
`endif
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        logic data_sel;
        data_sel = sel && (id != 2'd3);
        if (!rst_n) begin
            m_rd_pend <= 1'b0; m_wr_pend <= 1'b0; m_err <= 1'b0;
            m_byp <= 1'b0; m_rd_ch <= '0; m_wr_ch <= '0;
            m_wr_data <= '0; m_chain <= '0;
        end else begin
            if (m_rd_pend) begin
                if (rd_ack) begin
                    m_chain <= rd_data;
                    m_rd_pend <= 1'b0;
                end
                if (data_sel && (cap_s || upd_s || sh_s)) m_err <= 1'b1;
            end else begin
                if (m_wr_pend) begin
                    if (wr_ack) m_wr_pend <= 1'b0;
                    if (data_sel && (cap_s || upd_s)) m_err <= 1'b1;
                end else if (data_sel && cap_s) begin
                    m_rd_pend <= 1'b1;
                    m_rd_ch <= id;
                end else if (data_sel && upd_s) begin
                    m_wr_pend <= 1'b1;
                    m_wr_ch <= id;
                    m_wr_data <= m_chain;
                end
                if (data_sel && sh_s) m_chain <= {tdi, m_chain[DW-1:1]};
            end
            if (sel && !data_sel) begin
                if (cap_s) m_byp <= 1'b0;
                else if (sh_s) m_byp <= tdi;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("cyc_tdo", 32'(tdo), 32'(m_tdo()));
            chk("cyc_rd_req", 32'(rd_req), 32'(m_rd_pend));
            chk("cyc_wr_req", 32'(wr_req), 32'(m_wr_pend));
            chk("cyc_seq_err", 32'(seq_err), 32'(m_err));
            chk("cyc_wr_data", wr_data, m_wr_data);
            if (m_rd_pend) chk("cyc_rd_ch", 32'(rd_ch), 32'(m_rd_ch));
            if (m_wr_pend) chk("cyc_wr_ch", 32'(wr_ch), 32'(m_wr_ch));
        end
    end

    task automatic step(input logic c, input logic u, input logic s,
                        input logic d, input logic ra, input logic wa);
        cap_s = c; upd_s = u; sh_s = s; tdi = d; rd_ack = ra; wr_ack = wa;
        @(posedge clk);
        #2;
    endtask

    task automatic idle();      step(0, 0, 0, 0, 0, 0); endtask
    task automatic do_cap();    step(1, 0, 0, 0, 0, 0); endtask
    task automatic do_upd();    step(0, 1, 0, 0, 0, 0); endtask
    task automatic do_sh(input logic b); step(0, 0, 1, b, 0, 0); endtask
    task automatic do_rack();   step(0, 0, 0, 0, 1, 0); endtask
    task automatic do_wack();   step(0, 0, 0, 0, 0, 1); endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
    endtask

    task automatic shift_out(output logic [31:0] v);
        for (int i = 0; i < DW; i++) begin
            v[i] = tdo;
            do_sh(1'b0);
        end
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] pat;
        logic [2:0]  bp;
        rst_n = 1'b0; sel = 1'b0; id = '0; rd_data = '0;
        idle();
        idle();
        mon_en = 1'b1;
        chk("rst_rd_req", 32'(rd_req), 32'd0);
        chk("rst_wr_req", 32'(wr_req), 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_tdo", 32'(tdo), 32'd0);
        chk("rst_seq_err", 32'(seq_err), 32'd0);
        rst_n = 1'b1;

        // Capture ch 1, ack three clocks later, shift it all out.
        sel = 1'b1; id = 2'd1;
        do_cap();
        chk("cap_rd_req", 32'(rd_req), 32'd1);
        chk("cap_rd_ch", 32'(rd_ch), 32'd1);
        idle();
        idle();
        rd_data = 32'hA5A5_0F0F;
        do_rack();
        chk("ack_rd_req", 32'(rd_req), 32'd0);
        shift_out(v);
        chk("cap_tdo_seq", v, 32'hA5A5_0F0F);
        chk("cap_seq_err", 32'(seq_err), 32'd0);

        // Shift in a word, update ch 0, ack two clocks later.
        pat = 32'h1234_5678;
        for (int i = 0; i < DW; i++) do_sh(pat[i]);
        id = 2'd0;
        do_upd();
        chk("upd_wr_req", 32'(wr_req), 32'd1);
        chk("upd_wr_ch", 32'(wr_ch), 32'd0);
        chk("upd_wr_data", wr_data, 32'h1234_5678);
        idle();
        do_wack();
        chk("wack_wr_req", 32'(wr_req), 32'd0);

        // Shift during RD_WAIT is rejected and flagged.
        id = 2'd2;
        do_cap();
        do_sh(1'b1);
        chk("rdw_shift_err", 32'(seq_err), 32'd1);
        rd_data = 32'hDEAD_BEEF;
        do_rack();
        shift_out(v);
        chk("rdw_data", v, 32'hDEAD_BEEF);
        idle();
        chk("err_sticky", 32'(seq_err), 32'd1);
        do_reset();
        chk("err_cleared", 32'(seq_err), 32'd0);

        // Ack and new capture in one cycle: ack wins, capture is an error.
        id = 2'd1;
        do_cap();
        rd_data = 32'h0000_00F1;
        step(1, 0, 0, 0, 1, 0);
        chk("ackcap_rd_req", 32'(rd_req), 32'd0);
        chk("ackcap_err", 32'(seq_err), 32'd1);
        chk("ackcap_tdo", 32'(tdo), 32'd1);

        // Update during WR_WAIT is ignored and flagged.
        do_reset();
        for (int i = 0; i < 8; i++) do_sh(1'b1);
        do_upd();
        chk("wrw_wr_data0", wr_data, 32'hFF00_0000);
        id = 2'd2;
        do_upd();
        chk("wrw_wr_ch", 32'(wr_ch), 32'd1);
        chk("wrw_wr_data1", wr_data, 32'hFF00_0000);
        chk("wrw_err", 32'(seq_err), 32'd1);
        do_sh(1'b0);
        do_wack();
        chk("wrw_wr_req", 32'(wr_req), 32'd0);

        // Reset mid-read; the late ack lands in IDLE and is dropped.
        do_reset();
        id = 2'd0;
        do_cap();
        do_reset();
        rd_data = 32'hFFFF_FFFF;
        do_rack();
        chk("rstrd_rd_req", 32'(rd_req), 32'd0);
        chk("rstrd_tdo", 32'(tdo), 32'd0);
        chk("rstrd_err", 32'(seq_err), 32'd0);
        do_cap();
        chk("rstrd_recap", 32'(rd_req), 32'd1);
        do_rack();
        chk("rstrd_load", 32'(tdo), 32'd1);

        // Strobes while deselected do nothing.
        sel = 1'b0;
        do_cap();
        do_upd();
        chk("nosel_rd_req", 32'(rd_req), 32'd0);
        chk("nosel_wr_req", 32'(wr_req), 32'd0);
        chk("nosel_err", 32'(seq_err), 32'd0);

        // Bypass chain: tdo follows tdi one strobe later, or stays 0.
        sel = 1'b1; id = 2'd3;
        bp = 3'b101;
        for (int i = 0; i < 3; i++) begin
            do_sh(bp[i]);
`ifdef SCR1_DBGC_DAP_BYPASS_EN
            chk("byp_tdo", 32'(tdo), 32'(bp[i]));
`else
            chk("byp_tdo", 32'(tdo), 32'd0);
`endif
        end
        do_cap();
        chk("byp_cap_tdo", 32'(tdo), 32'd0);
        chk("byp_cap_rd_req", 32'(rd_req), 32'd0);
        sel = 1'b0;
        idle();
        chk("desel_tdo", 32'(tdo), 32'd0);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scr1_dbgc_dap_chain.md
# scr1_dbgc_dap_chain

SysCLK-domain scan-chain engine that sits directly downstream of the TAP clock-domain synchronizer and consumes its core-side DAP strobes: chain select, chain id, capture, shift, update and TDI. It owns the DATA_W-bit shift register and drives TDO back toward the synchronizer. Capture and update are converted into read and write request/acknowledge transactions toward the debug controller register file.

## Interface
Parameters:
- DATA_W, 32, data-chain length in bits (≥2)
- CH_ID_W, SCR1_DBGC_DAP_CH_ID_WIDTH, chain id width

Ports:
- clk  in  1  system clock (SysCLK)
- rst_n  in  1  reset; synchronous, active-low
- dap_ch_sel_core  in  1  DAP chain selected (level)
- dap_ch_id_core  in  CH_ID_W  selected chain id (level)
- dap_ch_capture_core  in  1  capture strobe, one clk wide
- dap_ch_shift_core  in  1  shift strobe, one clk wide
- dap_ch_update_core  in  1  update strobe, one clk wide
- dap_ch_tdi_core  in  1  serial data in, valid with shift strobe
- dap_ch_tdo_core  out  1  serial data out
- rd_req  out  1  capture read request, held until rd_ack
- rd_ch  out  CH_ID_W  chain id of read, stable while rd_req
- rd_ack  in  1  read acknowledge; rd_data valid this cycle
- rd_data  in  DATA_W  captured value
- wr_req  out  1  update write request, held until wr_ack
- wr_ch  out  CH_ID_W  chain id of write
- wr_data  out  DATA_W  value written, stable while wr_req
- wr_ack  in  1  write acknowledge
- seq_err  out  1  sticky protocol-error flag

## Operation
- Chain ids 0..2 are data chains of DATA_W bits; id 3 (all-ones) is the bypass chain.
- Active = dap_ch_sel_core && id != all-ones.
- FSM states:
  - IDLE
  - RD_WAIT: read outstanding
  - WR_WAIT: write outstanding
- IDLE + capture && active → rd_req=1, rd_ch latched, go to RD_WAIT.
- RD_WAIT + rd_ack → sreg ← rd_data, rd_req=0, go to IDLE.
- IDLE + update && active → wr_req=1, wr_ch/wr_data ← id/sreg, go to WR_WAIT.
- WR_WAIT + wr_ack → wr_req=0, go to IDLE.
- Shift strobe while active and not in RD_WAIT: sreg ← {tdi, sreg[DATA_W-1:1]} (LSB first out).
- dap_ch_tdo_core = sreg[0] when active; otherwise per Configuration.
- Protocol errors set seq_err; it clears only on reset:
  - capture in RD_WAIT or WR_WAIT: ignored
  - update in RD_WAIT or WR_WAIT: ignored
  - shift in RD_WAIT: ignored, sreg unchanged
  - Shift during WR_WAIT is legal; wr_data is already latched.
- Strobes while not selected: capture and update are no-ops with no error.
- Simultaneous rd_ack and a new capture: the ack is consumed, the capture is an error.
- Reset mid-transaction: state → IDLE and requests dropped next edge. A late ack arriving in IDLE is ignored.

## Timing
- Reset values: rd_req=0, wr_req=0, rd_ch=0, wr_ch=0, wr_data=0, seq_err=0, sreg=0, dap_ch_tdo_core=0.
- Capture strobe at edge N → rd_req high after edge N.
- rd_ack sampled at edge M → sreg loaded at M, rd_req low after M. Minimum turnaround is 1 clk (ack same cycle as req).
- Shift strobe at edge N → new sreg[0] on dap_ch_tdo_core after N (registered source, no combinational path from tdi).
- Update strobe at edge N → wr_req/wr_data valid after N; wr_ack at edge K drops wr_req after K.
- dap_ch_sel_core/id are sampled only on strobe cycles.

## Configuration
- SCR1_DBGC_DAP_BYPASS_EN defined:
  - 1-bit bypass register byp, reset 0.
  - Shift while selected and not active (bypass id): byp ← tdi.
  - dap_ch_tdo_core = byp for that case.
  - Capture on bypass loads byp=0.
- Undefined: no bypass register; dap_ch_tdo_core=0 whenever not active.

## Structure
- Shared package scr1_dbgc_pkg holds:
  - chain-id localparams (SCR1_DBGC_DAP_CH_CTRL=0, _DATA=1, _STATUS=2, _BYPASS=3)
  - FSM state enum type_scr1_dap_chain_fsm_e
- Natural sub-module: scr1_dbgc_dap_sreg (shift register with load/shift/bypass), instantiated once. FSM and handshake logic live in the top.

## Test plan
- Capture ch 1, rd_data=32'hA5A5_0F0F acked after 3 clk; 32 shifts with tdi=0 → tdo sequence is bits 0..31 of A5A50F0F LSB first; seq_err=0.
- 32 shifts of 32'h1234_5678 LSB first, then update ch 0 → wr_req with wr_ch=0, wr_data=32'h12345678; wr_ack 2 clk later drops wr_req.
- Shift during RD_WAIT → sreg unchanged after ack, seq_err=1, held until rst_n low.
- Update in WR_WAIT → second write not issued, seq_err=1; first wr_data unchanged.
- rst_n low during RD_WAIT with rd_ack arriving next cycle → rd_req=0, sreg=0, ack ignored, state IDLE.
- With SCR1_DBGC_DAP_BYPASS_EN, id=3 selected, tdi pattern 1,0,1 → tdo 1,0,1 delayed one strobe; without the macro, tdo stays 0.
